// File: rtl/jesd204b_pkg.sv
// ----------------------------------------------------------------------------
// jesd204b_pkg
// Shared types and helpers for the JESD204B SYSREF/LMFC blocks.
//   sysref_mode_e  : SYSREF sequence flavour (one-shot, burst, continuous)
//   sysref_state_e : SYSREF generator sequencing states
//   lmfc_cycles()  : device-clock cycles per local multiframe
// ----------------------------------------------------------------------------
package jesd204b_pkg;

   typedef enum logic [1:0] {
      SYSREF_ONESHOT = 2'd0,
      SYSREF_BURST   = 2'd1,
      SYSREF_CONT    = 2'd2
   } sysref_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      PULSE = 2'd2,
      DONE  = 2'd3
   } sysref_state_e;

   // Device-clock cycles per multiframe: F*K octets carried OCTETS_PER_DCLK at a time.
   function automatic int lmfc_cycles(input int f, input int k, input int octets_per_dclk);
      return (f * k) / octets_per_dclk;
   endfunction

endpackage

// File: rtl/jesd204b_lmfc_counter.sv
// ----------------------------------------------------------------------------
// jesd204b_lmfc_counter
// Free-running local multiframe phase counter, 0..CYC-1, wrapping every CYC
// clocks. Shared by the SYSREF source and the receive-side LMFC logic.
//   clk   : device clock
//   rst_n : asynchronous active-low reset, phase restarts at 0
//   cnt   : current LMFC phase (registered)
//   last  : high while cnt is at the final phase CYC-1
// ----------------------------------------------------------------------------
module jesd204b_lmfc_counter #(
   parameter int CYC = 4,
   parameter int W   = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [W-1:0] cnt,
   output logic         last
);

   localparam logic [W-1:0] CNT_LAST = W'(CYC - 1);

   logic [W-1:0] cnt_r;

   // Phase counter: increments every clock, wraps at the multiframe boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + W'(1);
      end
   end

   assign cnt  = cnt_r;
   assign last = (cnt_r == CNT_LAST);

endmodule

// File: rtl/jesd204b_sysref_generator.sv
// ----------------------------------------------------------------------------
// jesd204b_sysref_generator
// SYSREF source: emits one-shot, burst or continuous SYSREF pulses whose
// rising edges land on the local LMFC boundary (o_lmfc_cnt == 0).
//   dclk       : device clock
//   rst_n      : asynchronous active-low reset
//   start      : request a sequence (only honoured in IDLE, and not with stop)
//   stop       : abort any running sequence, highest priority
//   cfg_mode   : 0 one-shot, 1 burst, 2 continuous, 3 one-shot
//   cfg_mult   : period in LMFC periods (0 behaves as 1)
//   cfg_count  : burst pulse count (0 behaves as 1)
//   cfg_width  : high time in dclk cycles (0 behaves as 1)
//   o_sysref   : registered SYSREF
//   o_busy     : sequence in progress (ALIGN or PULSE)
//   o_done     : one-cycle pulse on normal completion
//   o_lmfc_cnt : local LMFC phase
// ----------------------------------------------------------------------------
module jesd204b_sysref_generator
   import jesd204b_pkg::*;
#(
   parameter int JESD_F          = 1,
   parameter int JESD_K          = 16,
   parameter int OCTETS_PER_DCLK = 4,
   parameter int PW_WIDTH        = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                 dclk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic [1:0]           cfg_mode,
   input  logic [CNT_WIDTH-1:0] cfg_mult,
   input  logic [CNT_WIDTH-1:0] cfg_count,
   input  logic [PW_WIDTH-1:0]  cfg_width,
   output logic                 o_sysref,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [CNT_WIDTH-1:0] o_lmfc_cnt
);

   localparam int LMFC_CYC = lmfc_cycles(JESD_F, JESD_K, OCTETS_PER_DCLK);
   localparam int LMFC_W   = $clog2(LMFC_CYC);
   // Wide enough for mult*LMFC_CYC and for any cfg_width value.
   localparam int PER_W    = (CNT_WIDTH + LMFC_W > PW_WIDTH) ? (CNT_WIDTH + LMFC_W) : PW_WIDTH;

   if (((JESD_F * JESD_K) % OCTETS_PER_DCLK) != 0 || LMFC_CYC < 2 ||
       LMFC_CYC > (2 ** CNT_WIDTH)) begin : g_bad_lmfc_cfg
      $error("jesd204b_sysref_generator: LMFC_CYC must be an integer >= 2 that fits CNT_WIDTH");
   end

   logic                 lmfc_last_s;
   logic [CNT_WIDTH-1:0] lmfc_cnt_s;

   jesd204b_lmfc_counter #(
      .CYC (LMFC_CYC),
      .W   (CNT_WIDTH)
   ) u_lmfc (
      .clk   (dclk),
      .rst_n (rst_n),
      .cnt   (lmfc_cnt_s),
      .last  (lmfc_last_s)
   );

   // Configuration as it would be latched now, zero substitutions and clamp applied.
   sysref_mode_e         cfg_mode_s;
   logic [CNT_WIDTH-1:0] cfg_mult_s;
   logic [CNT_WIDTH-1:0] cfg_pulses_s;
   logic [PW_WIDTH-1:0]  cfg_width_raw_s;
   logic [PER_W-1:0]     cfg_period_s;
   logic [PER_W-1:0]     cfg_width_s;

   // Sequencer registers and their next values.
   sysref_state_e        state_r,       state_s;
   sysref_mode_e         mode_r,        mode_s;
   logic [PER_W-1:0]     period_r,      period_s;
   logic [PER_W-1:0]     width_r,       width_s;
   logic [PER_W-1:0]     per_cnt_r,     per_cnt_s;
   logic [CNT_WIDTH-1:0] pulses_left_r, pulses_left_s;
   logic                 sysref_r,      sysref_s;
   logic                 busy_r,        busy_s;
   logic                 done_r,        done_s;

   // Decode the live configuration into the values a start would latch.
   always_comb begin
      cfg_mult_s      = (cfg_mult  == '0) ? CNT_WIDTH'(1) : cfg_mult;
      cfg_width_raw_s = (cfg_width == '0) ? PW_WIDTH'(1)  : cfg_width;
      cfg_period_s    = PER_W'(cfg_mult_s) * PER_W'(LMFC_CYC);
      // Keep at least one low cycle per period so every edge is visible.
      if (PER_W'(cfg_width_raw_s) >= cfg_period_s) begin
         cfg_width_s = cfg_period_s - PER_W'(1);
      end else begin
         cfg_width_s = PER_W'(cfg_width_raw_s);
      end
      case (cfg_mode)
         2'd1:    cfg_mode_s = SYSREF_BURST;
         2'd2:    cfg_mode_s = SYSREF_CONT;
         default: cfg_mode_s = SYSREF_ONESHOT;
      endcase
      if (cfg_mode_s == SYSREF_BURST) begin
         cfg_pulses_s = (cfg_count == '0) ? CNT_WIDTH'(1) : cfg_count;
      end else begin
         cfg_pulses_s = CNT_WIDTH'(1);
      end
   end

   // Next-state, period tracking and next registered output values.
   always_comb begin
      state_s       = state_r;
      mode_s        = mode_r;
      period_s      = period_r;
      width_s       = width_r;
      per_cnt_s     = per_cnt_r;
      pulses_left_s = pulses_left_r;
      case (state_r)
         IDLE: begin
            if (start && !stop) begin
               state_s       = ALIGN;
               mode_s        = cfg_mode_s;
               period_s      = cfg_period_s;
               width_s       = cfg_width_s;
               pulses_left_s = cfg_pulses_s;
            end else begin
               state_s = IDLE;
            end
         end
         ALIGN: begin
            if (stop) begin
               state_s = IDLE;
            end else if (lmfc_last_s) begin
               // The counter wraps to 0 on this edge, so the first high cycle is LMFC-aligned.
               state_s   = PULSE;
               per_cnt_s = '0;
            end else begin
               state_s = ALIGN;
            end
         end
         PULSE: begin
            if (stop) begin
               state_s = IDLE;
            end else if (per_cnt_r == (period_r - PER_W'(1))) begin
               per_cnt_s = '0;
               if (mode_r == SYSREF_CONT) begin
                  state_s = PULSE;
               end else begin
                  pulses_left_s = pulses_left_r - CNT_WIDTH'(1);
                  if (pulses_left_r == CNT_WIDTH'(1)) begin
                     state_s = DONE;
                  end else begin
                     state_s = PULSE;
                  end
               end
            end else begin
               per_cnt_s = per_cnt_r + PER_W'(1);
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      sysref_s = (state_s == PULSE) && (per_cnt_s < width_r);
      busy_s   = (state_s == ALIGN) || (state_s == PULSE);
      done_s   = (state_s == DONE);
   end

   // Sequencer state, latched configuration and registered outputs.
   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         mode_r        <= SYSREF_ONESHOT;
         period_r      <= '0;
         width_r       <= '0;
         per_cnt_r     <= '0;
         pulses_left_r <= '0;
         sysref_r      <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         mode_r        <= mode_s;
         period_r      <= period_s;
         width_r       <= width_s;
         per_cnt_r     <= per_cnt_s;
         pulses_left_r <= pulses_left_s;
         sysref_r      <= sysref_s;
         busy_r        <= busy_s;
         done_r        <= done_s;
      end
   end

   assign o_sysref   = sysref_r;
   assign o_busy     = busy_r;
   assign o_done     = done_r;
   assign o_lmfc_cnt = lmfc_cnt_s;

endmodule

// File: tb/tb_jesd204b_sysref_generator.sv
// ----------------------------------------------------------------------------
// tb_jesd204b_sysref_generator
// Directed bench for jesd204b_sysref_generator. A timeline model predicts, for
// every cycle index, the SYSREF / busy / done / LMFC values from the accepted
// start cycle, the first LMFC-aligned rise and the latched period, width and
// pulse count. Scenario checks pin the model with hand-derived numbers.
// ----------------------------------------------------------------------------
module tb_jesd204b_sysref_generator;

   localparam int JESD_F = 1;
   localparam int JESD_K = 16;
   localparam int OPD    = 4;
   localparam int PW_W   = 4;
   localparam int CNT_W  = 8;
   localparam int L      = JESD_F * JESD_K / OPD;

   logic             dclk;
   logic             rst_n;
   logic             start;
   logic             stop;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_mult;
   logic [CNT_W-1:0] cfg_count;
   logic [PW_W-1:0]  cfg_width;
   logic             o_sysref;
   logic             o_busy;
   logic             o_done;
   logic [CNT_W-1:0] o_lmfc_cnt;

   jesd204b_sysref_generator #(
      .JESD_F          (JESD_F),
      .JESD_K          (JESD_K),
      .OCTETS_PER_DCLK (OPD),
      .PW_WIDTH        (PW_W),
      .CNT_WIDTH       (CNT_W)
   ) dut (
      .dclk       (dclk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .cfg_mode   (cfg_mode),
      .cfg_mult   (cfg_mult),
      .cfg_count  (cfg_count),
      .cfg_width  (cfg_width),
      .o_sysref   (o_sysref),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_lmfc_cnt (o_lmfc_cnt)
   );

   initial dclk = 1'b0;
   always #5 dclk = ~dclk;

   int n_checks = 0;
   int n_pass   = 0;
   bit run      = 1'b0;

   // Model: cycle index since reset plus the timeline of the accepted sequence.
   int cyc    = 0;
   bit m_act  = 1'b0;
   int m_s0   = 0;
   int m_rise = 0;
   int m_per  = 1;
   int m_w    = 0;
   int m_np   = 0;   // 0 means unlimited (continuous)

   // Observation log.
   int   rise_q[$];
   int   rise_lmfc_q[$];
   int   high_cnt      = 0;
   int   done_cnt      = 0;
   int   last_done_cyc = -1;
   int   busy_rise_cyc = -1;
   logic prev_sysref   = 1'b0;
   logic prev_busy     = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int first_rise(input int s);
      int c;
      c = s + 2;
      while ((c % L) != 0) c++;
      return c;
   endfunction

   function automatic int m_end();
      return m_rise + m_np * m_per;
   endfunction

   function automatic bit exp_sysref(input int c);
      return m_act && (c >= m_rise) && (m_np == 0 || c < m_end()) &&
             (((c - m_rise) % m_per) < m_w);
   endfunction

   function automatic bit exp_busy(input int c);
      return m_act && (c > m_s0) && (m_np == 0 || c < m_end());
   endfunction

   function automatic bit exp_done(input int c);
      return m_act && (m_np != 0) && (c == m_end());
   endfunction

   function automatic bit m_idle(input int c);
      return !(exp_busy(c) || exp_done(c));
   endfunction

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // Model update: accept start in idle, abort on stop, advance the cycle index.
   always @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         cyc   <= 0;
         m_act <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (stop) begin
            if (!m_idle(cyc)) m_act <= 1'b0;
         end else if (start && m_idle(cyc)) begin
            m_act  <= 1'b1;
            m_s0   <= cyc;
            m_rise <= first_rise(cyc);
            m_per  <= eff(int'(cfg_mult)) * L;
            m_w    <= (eff(int'(cfg_width)) < eff(int'(cfg_mult)) * L) ?
                      eff(int'(cfg_width)) : eff(int'(cfg_mult)) * L - 1;
            m_np   <= (cfg_mode == 2'd1) ? eff(int'(cfg_count)) :
                      (cfg_mode == 2'd2) ? 0 : 1;
         end
      end
   end

   // Per-cycle compare against the model, plus the observation log.
   always @(negedge dclk) begin
      if (rst_n && run) begin
         chk("lmfc_cnt", int'(o_lmfc_cnt), cyc % L);
         chk("sysref",   int'(o_sysref),   int'(exp_sysref(cyc)));
         chk("busy",     int'(o_busy),     int'(exp_busy(cyc)));
         chk("done",     int'(o_done),     int'(exp_done(cyc)));
         if (o_sysref && !prev_sysref) begin
            rise_q.push_back(cyc);
            rise_lmfc_q.push_back(int'(o_lmfc_cnt));
         end
         if (o_sysref) high_cnt++;
         if (o_done) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (o_busy && !prev_busy) busy_rise_cyc = cyc;
         prev_sysref = o_sysref;
         prev_busy   = o_busy;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge dclk);
         #1;
      end
   endtask

   task automatic set_cfg(input int mode, input int mult, input int count, input int width);
      cfg_mode  = 2'(mode);
      cfg_mult  = CNT_W'(mult);
      cfg_count = CNT_W'(count);
      cfg_width = PW_W'(width);
   endtask

   task automatic go(output int s);
      s     = cyc;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_lmfc(input int v);
      for (int i = 0; i < 2 * L && (cyc % L) != v; i++) tick(1);
   endtask

   task automatic wait_rises(input int target, input string nm);
      int i;
      i = 0;
      while (rise_q.size() < target && i < 60) begin
         tick(1);
         i++;
      end
      chk({nm, "_rise_timeout"}, int'(rise_q.size() >= target), 1);
   endtask

   int s;
   int rb;
   int hb;
   int db;
   int lmfc_exp[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      set_cfg(0, 1, 1, 1);
      #3;
      chk("reset_sysref", int'(o_sysref), 0);
      chk("reset_busy",   int'(o_busy),   0);
      chk("reset_done",   int'(o_done),   0);
      chk("reset_lmfc",   int'(o_lmfc_cnt), 0);
      #9;
      rst_n = 1'b1;
      run   = 1'b1;
      tick(3);

      // 1: one-shot, width 2, start while lmfc_cnt == 1 (count is ignored).
      set_cfg(0, 1, 5, 2);
      wait_lmfc(1);
      rb = rise_q.size(); hb = high_cnt; db = done_cnt;
      go(s);
      tick(10);
      chk("os_busy_rise", busy_rise_cyc, s + 1);
      chk("os_rises", rise_q.size() - rb, 1);
      if (rise_q.size() > rb) begin
         chk("os_rise_cyc",  rise_q[rb], s + 3);
         chk("os_rise_lmfc", rise_lmfc_q[rb], 0);
         chk("os_done_cyc",  last_done_cyc, rise_q[rb] + 4);
      end
      chk("os_high", high_cnt - hb, 2);
      chk("os_done", done_cnt - db, 1);

      // 2: burst of 3, mult 2, width 1.
      set_cfg(1, 2, 3, 1);
      rb = rise_q.size(); hb = high_cnt; db = done_cnt;
      go(s);
      tick(40);
      chk("bu_rises", rise_q.size() - rb, 3);
      if (rise_q.size() >= rb + 3) begin
         for (int i = 0; i < 3; i++) chk("bu_rise_lmfc", rise_lmfc_q[rb + i], 0);
         chk("bu_space1", rise_q[rb + 1] - rise_q[rb], 8);
         chk("bu_space2", rise_q[rb + 2] - rise_q[rb + 1], 8);
         chk("bu_done_cyc", last_done_cyc, rise_q[rb] + 24);
      end
      chk("bu_high", high_cnt - hb, 3);
      chk("bu_done", done_cnt - db, 1);
      chk("bu_busy_after", int'(o_busy), 0);

      // 3: continuous, width 9 clamps to 3; stop in the second high cycle of the third pulse.
      set_cfg(2, 1, 1, 9);
      rb = rise_q.size(); hb = high_cnt; db = done_cnt;
      go(s);
      wait_rises(rb + 3, "ct");
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("ct_stop_sysref", int'(o_sysref), 0);
      chk("ct_stop_busy",   int'(o_busy),   0);
      tick(6);
      chk("ct_high", high_cnt - hb, 8);
      chk("ct_done", done_cnt - db, 0);
      if (rise_q.size() >= rb + 3) begin
         chk("ct_space", rise_q[rb + 2] - rise_q[rb + 1], 4);
      end

      // 4: zero config in burst mode -> one pulse, period 4, width 1.
      set_cfg(1, 0, 0, 0);
      rb = rise_q.size(); hb = high_cnt; db = done_cnt;
      go(s);
      tick(15);
      chk("zc_rises", rise_q.size() - rb, 1);
      chk("zc_high",  high_cnt - hb, 1);
      chk("zc_done",  done_cnt - db, 1);
      if (rise_q.size() > rb) chk("zc_done_cyc", last_done_cyc, rise_q[rb] + 4);

      // 5: start and cfg changes while busy are ignored; start+stop in idle is ignored.
      set_cfg(1, 1, 2, 2);
      rb = rise_q.size(); hb = high_cnt; db = done_cnt;
      go(s);
      tick(4);
      set_cfg(2, 3, 7, 1);
      start = 1'b1;
      tick(6);
      start = 1'b0;
      tick(10);
      chk("sb_rises", rise_q.size() - rb, 2);
      chk("sb_high",  high_cnt - hb, 4);
      chk("sb_done",  done_cnt - db, 1);
      if (rise_q.size() > rb) chk("sb_done_cyc", last_done_cyc, rise_q[rb] + 8);
      rb = rise_q.size();
      start = 1'b1;
      stop  = 1'b1;
      tick(1);
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_busy", int'(o_busy), 0);
      tick(10);
      chk("ss_rises", rise_q.size() - rb, 0);

      // 6: asynchronous reset in the middle of a burst pulse.
      set_cfg(1, 2, 3, 4);
      rb = rise_q.size();
      go(s);
      wait_rises(rb + 1, "rs");
      #1;
      rst_n = 1'b0;
      #1;
      chk("rs_sysref", int'(o_sysref), 0);
      chk("rs_busy",   int'(o_busy),   0);
      chk("rs_done",   int'(o_done),   0);
      chk("rs_lmfc",   int'(o_lmfc_cnt), 0);
      @(posedge dclk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge dclk);
         #1;
         chk("rs_lmfc_seq", int'(o_lmfc_cnt), lmfc_exp[i]);
      end
      rb = rise_q.size();
      tick(12);
      chk("rs_no_pulse", rise_q.size() - rb, 0);
      chk("rs_busy_after", int'(o_busy), 0);

      run = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
